alu_commit_arbiter: RTL
=======================

// Module: alu_commit_arbiter
// PURPOSE
//  Commiter-side endpoint of the ALU result interface (res/o_rd/valid/o_error/clear). Collects
//  results from N_ALU execution units, grants one at a time round-robin, writes it to the
//  register file, and pulses clear back to the granted ALU so it returns to IDLE.
//  Routes ALU errors (e.g. div-by-zero) to the trap logic. Sits between the ALUs and the regfile port.
// PARAMETERS
//  N_ALU       4   number of ALU result channels (>=2)
//  XLEN        32  data width (core_config_pkg::XLEN)
//  REG_ADDR_W  5   register index width (core_config_pkg::REG_ADDR_W)
// PORTS
//  clk        in   1                 core clock
//  rst        in   1                 synchronous, active-high reset
//  alu_res    in   N_ALU*XLEN        result of ALU i at [i*XLEN +: XLEN]
//  alu_rd     in   N_ALU*REG_ADDR_W  destination reg of ALU i
//  alu_valid  in   N_ALU             ALU i holds a result (stable until cleared)
//  alu_error  in   N_ALU             ALU i result is erroneous
//  alu_clear  out  N_ALU             one-cycle release pulse to ALU i
//  flush      in   1                 pipeline flush: drop every pending result
//  wb_en      out  1                 regfile write strobe
//  wb_rd      out  REG_ADDR_W        regfile write address
//  wb_data    out  XLEN              regfile write data
//  exc_valid  out  1                 error pending toward trap logic
//  exc_src    out  $clog2(N_ALU)     index of erroring ALU
//  exc_ack    in   1                 trap logic accepted the error
//  retire_cnt out  XLEN              count of results written back (wraps)
// BEHAVIOUR
//  Reset: state=ARB, all outputs 0, last_grant=N_ALU-1 (ALU0 highest priority first), retire_cnt=0.
//  FSM states ARB, COMMIT, ERR.
//  ARB: if any alu_valid, grant first valid index scanning last_grant+1 .. wrapping mod N_ALU;
//   register sel, res, rd, error; last_grant<=sel. Next: error ? ERR : COMMIT. None valid: stay.
//  COMMIT (1 cycle): alu_clear[sel]=1; wb_en=1 with registered rd/data unless rd==0 (wb_en=0, clear
//   still pulsed); retire_cnt+1 only when wb_en=1. Next: ARB.
//  ERR: exc_valid=1, exc_src=sel, wb_en=0, no clear until exc_ack. exc_ack cycle: alu_clear[sel]=1,
//   exc_valid still 1 that cycle, next ARB. Error results never written back.
//  Throughput: one result per 2 cycles; latency valid->wb_en = 1 cycle from ARB sampling.
//  ALU drops valid the cycle after clear; ARB never samples in that cycle, so no double grant.
//  flush (any state, priority over exc_ack and arbitration): alu_clear = alu_valid (all
//   holders released), wb_en=0, exc_valid=0, next ARB; last_grant unchanged.
//  alu_clear is one-hot or zero except during flush. Data/rd outputs are 0 whenever wb_en=0.
//  rst mid-operation: return to reset values next edge; no clear pulsed, no writeback.
// TESTING
//  ALU1 valid, rd=5, res=0xDEADBEEF -> ARB then COMMIT: wb_en=1 rd=5 data=0xDEADBEEF, alu_clear=0b0010, retire_cnt=1.
//  ALU0..3 all valid after reset -> grants in order 0,1,2,3 on wb every 2 cycles; ALU0 re-valid at end -> granted after 3.
//  ALU2 valid rd=0 -> COMMIT with wb_en=0, alu_clear=0b0100, retire_cnt unchanged.
//  ALU3 valid+error -> exc_valid=1 exc_src=3 held 5 cycles without ack; exc_ack -> alu_clear=0b1000, back to ARB, no wb.
//  ALU0,2 valid, flush in COMMIT of ALU0 -> wb_en=0, alu_clear=0b0101, state ARB next cycle.
//  rst asserted during ERR -> next cycle exc_valid=0, alu_clear=0, retire_cnt=0, state ARB.

Source files
------------

// File: rtl/alu_commit_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_commit_arbiter_if
// Result bus between N_ALU execution units and the commit arbiter.
//   alu_res   : result of ALU i at [i*XLEN +: XLEN]
//   alu_rd    : destination register of ALU i at [i*REG_ADDR_W +: REG_ADDR_W]
//   alu_valid : ALU i holds a result (held stable until cleared)
//   alu_error : ALU i result is erroneous (e.g. divide by zero)
//   alu_clear : one-cycle release pulse back to ALU i
// Modports: master = ALU side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_commit_arbiter_if #(
   parameter int N_ALU      = 4,
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic [N_ALU*XLEN-1:0]       alu_res;
   logic [N_ALU*REG_ADDR_W-1:0] alu_rd;
   logic [N_ALU-1:0]            alu_valid;
   logic [N_ALU-1:0]            alu_error;
   logic [N_ALU-1:0]            alu_clear;

   modport master (
      output alu_res, alu_rd, alu_valid, alu_error,
      input  alu_clear
   );

   modport slave (
      input  alu_res, alu_rd, alu_valid, alu_error,
      output alu_clear
   );
endinterface

// File: rtl/alu_commit_arbiter.sv
// ---------------------------------------------------------------------------
// alu_commit_arbiter
// Commit-side endpoint of the ALU result bus. Grants one ALU result at a
// time in round-robin order, writes it to the register file, releases the
// ALU with a clear pulse, and routes erroneous results to the trap logic.
// Ports:
//   clk_i, rst_i   : core clock, synchronous active-high reset
//   alu_if         : ALU result bus (slave side)
//   flush_i        : drop every pending result, release all holders
//   wb_en_o        : regfile write strobe
//   wb_rd_o        : regfile write address (0 when wb_en_o=0)
//   wb_data_o      : regfile write data (0 when wb_en_o=0)
//   exc_valid_o    : error pending toward trap logic
//   exc_src_o      : index of the erroring ALU
//   exc_ack_i      : trap logic accepted the error
//   retire_cnt_o   : number of results written back (wraps)
// ---------------------------------------------------------------------------
module alu_commit_arbiter #(
   parameter int N_ALU      = 4,
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   localparam int SEL_W     = (N_ALU > 1) ? $clog2(N_ALU) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   alu_commit_arbiter_if.slave   alu_if,
   input  logic                  flush_i,
   output logic                  wb_en_o,
   output logic [REG_ADDR_W-1:0] wb_rd_o,
   output logic [XLEN-1:0]       wb_data_o,
   output logic                  exc_valid_o,
   output logic [SEL_W-1:0]      exc_src_o,
   input  logic                  exc_ack_i,
   output logic [XLEN-1:0]       retire_cnt_o
);

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_COMMIT = 2'd1,
      ST_ERR    = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [SEL_W-1:0]        last_q, last_d;
   logic [XLEN-1:0]         res_q, res_d;
   logic [REG_ADDR_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]         cnt_q, cnt_d;

   logic [SEL_W-1:0]        pick_s;
   logic [N_ALU-1:0]        clear_s;
   logic                    wb_en_s;
   logic [REG_ADDR_W-1:0]   wb_rd_s;
   logic [XLEN-1:0]         wb_data_s;
   logic                    exc_valid_s;
   logic [SEL_W-1:0]        exc_src_s;

   // First requester after 'last', wrapping modulo N_ALU (last itself is lowest).
   function automatic logic [SEL_W-1:0] rr_pick(input logic [N_ALU-1:0] req,
                                                input logic [SEL_W-1:0] last);
      logic [SEL_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= N_ALU; i++) begin
         idx = int'(last) + i;
         if (idx >= N_ALU) begin
            idx = idx - N_ALU;
         end else begin
            idx = idx;
         end
         if (!found && req[idx]) begin
            pick  = SEL_W'(idx);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   // Round-robin candidate for the current request vector.
   always_comb begin
      pick_s = rr_pick(alu_if.alu_valid, last_q);
   end

   // Next-state and output decode; reset blanks outputs, flush overrides everything else.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      last_d      = last_q;
      res_d       = res_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      clear_s     = '0;
      wb_en_s     = 1'b0;
      wb_rd_s     = '0;
      wb_data_s   = '0;
      exc_valid_s = 1'b0;
      exc_src_s   = '0;

      if (rst_i) begin
         state_d = ST_ARB;
      end else if (flush_i) begin
         // Release every holder; nothing is written or trapped this cycle.
         clear_s = alu_if.alu_valid;
         state_d = ST_ARB;
      end else begin
         case (state_q)
            ST_ARB: begin
               if (|alu_if.alu_valid) begin
                  sel_d   = pick_s;
                  last_d  = pick_s;
                  res_d   = alu_if.alu_res[pick_s*XLEN +: XLEN];
                  rd_d    = alu_if.alu_rd[pick_s*REG_ADDR_W +: REG_ADDR_W];
                  state_d = alu_if.alu_error[pick_s] ? ST_ERR : ST_COMMIT;
               end else begin
                  state_d = ST_ARB;
               end
            end
            ST_COMMIT: begin
               clear_s[sel_q] = 1'b1;
               // Writes to x0 are discarded but the ALU is still released.
               if (rd_q != {REG_ADDR_W{1'b0}}) begin
                  wb_en_s   = 1'b1;
                  wb_rd_s   = rd_q;
                  wb_data_s = res_q;
                  cnt_d     = cnt_q + XLEN'(1);
               end else begin
                  wb_en_s   = 1'b0;
               end
               state_d = ST_ARB;
            end
            ST_ERR: begin
               exc_valid_s = 1'b1;
               exc_src_s   = sel_q;
               if (exc_ack_i) begin
                  clear_s[sel_q] = 1'b1;
                  state_d        = ST_ARB;
               end else begin
                  state_d        = ST_ERR;
               end
            end
            default: begin
               state_d = ST_ARB;
            end
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_ARB;
         sel_q   <= '0;
         last_q  <= SEL_W'(N_ALU - 1);
         res_q   <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign alu_if.alu_clear = clear_s;
   assign wb_en_o          = wb_en_s;
   assign wb_rd_o          = wb_rd_s;
   assign wb_data_o        = wb_data_s;
   assign exc_valid_o      = exc_valid_s;
   assign exc_src_o        = exc_src_s;
   assign retire_cnt_o     = cnt_q;

endmodule
